data_bus_fabric: RTL and testbench

Parametrised data-side interconnect between the core's load/store port and NUM_SLAVES memory-mapped targets (data RAM, UART, LEDs, timer). Each access is decoded by the top address bits, forwarded to one slave with a req/ack handshake, and returned to the core with a one-cycle ready pulse. An access is terminated with an error if the slave stays silent for TIMEOUT cycles or if the address is unmapped. The block sits in the top level in place of the direct core-to-memory data wiring.

---
 rtl/data_bus_pkg.sv | 26 ++
 rtl/bus_timeout_counter.sv | 38 +++
 rtl/data_bus_fabric.sv | 181 ++++++++++++++++++
 tb/tb_data_bus_fabric.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_pkg
// Description : Shared types and constants for the data-side bus fabric:
//               FSM state encoding, default error read data and the
//               byte-strobe width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package data_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } bus_state_t;

    localparam logic [31:0] C_ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
    localparam int          C_BYTE_W           = 8;

    // Number of byte enables for a data bus of the given width.
    function automatic int strb_w(input int data_w);
        return data_w / C_BYTE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : bus_timeout_counter
// Description : Counts cycles spent waiting for a slave acknowledge.
//               expired is high while the count equals TIMEOUT-1, i.e. on the
//               last permitted wait cycle.
// Ports       : clk, reset (async, active-high), clear (sync, has priority),
//               enable (count up), expired (combinational flag)
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired = (r_count == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/data_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_fabric
// Description : Load/store interconnect from the core to NUM_SLAVES targets.
//               The top SEL_W address bits pick the slave; the access is
//               forwarded with a held one-hot req until ack or timeout and
//               returned to the core as a one-cycle ready pulse. Unmapped
//               addresses and silent slaves terminate with an error.
// Ports       : clk, reset (async, active-high)
//               core_*   : request side from the core, ready/rdata/err back
//               slv_*    : latched request fields out, ack/rdata in
//               err_count: saturating count of error responses
// Revision    : 1.0 - initial release
// ============================================================================
module data_bus_fabric
    import data_bus_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                NUM_SLAVES = 4,
    parameter int                SEL_W      = 2,
    parameter int                TIMEOUT    = 15,
    parameter logic [DATA_W-1:0] ERR_DATA   = DATA_W'(C_ERR_DATA_DEFAULT)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         core_req,
    input  logic                         core_we,
    input  logic [ADDR_W-1:0]            core_addr,
    input  logic [DATA_W-1:0]            core_wdata,
    input  logic [strb_w(DATA_W)-1:0]    core_wstrb,
    output logic                         core_ready,
    output logic [DATA_W-1:0]            core_rdata,
    output logic                         core_err,
    output logic [NUM_SLAVES-1:0]        slv_req,
    output logic                         slv_we,
    output logic [ADDR_W-1:0]            slv_addr,
    output logic [DATA_W-1:0]            slv_wdata,
    output logic [strb_w(DATA_W)-1:0]    slv_wstrb,
    input  logic [NUM_SLAVES-1:0]        slv_ack,
    input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata,
    output logic [15:0]                  err_count
);

    localparam int             C_STRB_W      = strb_w(DATA_W);
    localparam logic [SEL_W:0] C_NUM_SLAVES  = (SEL_W + 1)'(NUM_SLAVES);

    bus_state_t            r_state;
    bus_state_t            w_state_nxt;

    logic [SEL_W-1:0]      w_sel;
    logic                  w_mapped;
    logic [NUM_SLAVES-1:0] w_req_dec;
    logic                  w_ack;
    logic [DATA_W-1:0]     w_rdata_sel;
    logic                  w_expired;

    logic                  w_core_ready_nxt;
    logic [DATA_W-1:0]     w_core_rdata_nxt;
    logic                  w_core_err_nxt;
    logic [NUM_SLAVES-1:0] w_slv_req_nxt;
    logic                  w_slv_we_nxt;
    logic [ADDR_W-1:0]     w_slv_addr_nxt;
    logic [DATA_W-1:0]     w_slv_wdata_nxt;
    logic [C_STRB_W-1:0]   w_slv_wstrb_nxt;
    logic [15:0]           w_err_count_nxt;

    assign w_sel     = core_addr[ADDR_W-1 -: SEL_W];
    assign w_mapped  = ({1'b0, w_sel} < C_NUM_SLAVES);
    assign w_req_dec = NUM_SLAVES'(1) << w_sel;

    // slv_req is one-hot on the selected slave while waiting, so masking the
    // acks with it both selects the right ack and discards stray ones.
    assign w_ack = |(slv_ack & slv_req);

    always_comb begin
        w_rdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (slv_req[i]) begin
                w_rdata_sel = slv_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (r_state != WAIT),
        .enable  (r_state == WAIT),
        .expired (w_expired)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_core_ready_nxt = 1'b0;
        w_core_rdata_nxt = core_rdata;
        w_core_err_nxt   = core_err;
        w_slv_req_nxt    = slv_req;
        w_slv_we_nxt     = slv_we;
        w_slv_addr_nxt   = slv_addr;
        w_slv_wdata_nxt  = slv_wdata;
        w_slv_wstrb_nxt  = slv_wstrb;
        w_err_count_nxt  = err_count;

        case (r_state)
            IDLE: begin
                if (core_req) begin
                    w_slv_we_nxt    = core_we;
                    w_slv_addr_nxt  = core_addr;
                    w_slv_wdata_nxt = core_wdata;
                    w_slv_wstrb_nxt = core_wstrb;
                    if (w_mapped) begin
                        w_slv_req_nxt = w_req_dec;
                        w_state_nxt   = WAIT;
                    end else begin
                        w_core_ready_nxt = 1'b1;
                        w_core_err_nxt   = 1'b1;
                        w_core_rdata_nxt = ERR_DATA;
                        w_state_nxt      = RESP;
                    end
                end
            end
            WAIT: begin
                // Ack is tested first so an ack on the final count wins.
                if (w_ack) begin
                    w_slv_req_nxt    = '0;
                    w_core_ready_nxt = 1'b1;
                    w_core_err_nxt   = 1'b0;
                    w_core_rdata_nxt = slv_we ? '0 : w_rdata_sel;
                    w_state_nxt      = RESP;
                end else if (w_expired) begin
                    w_slv_req_nxt    = '0;
                    w_core_ready_nxt = 1'b1;
                    w_core_err_nxt   = 1'b1;
                    w_core_rdata_nxt = ERR_DATA;
                    w_state_nxt      = RESP;
                end
            end
            RESP: begin
                if (core_err && (err_count != 16'hFFFF)) begin
                    w_err_count_nxt = err_count + 16'd1;
                end
                w_state_nxt = IDLE;
            end
            default: begin
                w_slv_req_nxt = '0;
                w_state_nxt   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            core_ready <= 1'b0;
            core_rdata <= '0;
            core_err   <= 1'b0;
            slv_req    <= '0;
            slv_we     <= 1'b0;
            slv_addr   <= '0;
            slv_wdata  <= '0;
            slv_wstrb  <= '0;
            err_count  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            core_ready <= w_core_ready_nxt;
            core_rdata <= w_core_rdata_nxt;
            core_err   <= w_core_err_nxt;
            slv_req    <= w_slv_req_nxt;
            slv_we     <= w_slv_we_nxt;
            slv_addr   <= w_slv_addr_nxt;
            slv_wdata  <= w_slv_wdata_nxt;
            slv_wstrb  <= w_slv_wstrb_nxt;
            err_count  <= w_err_count_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_bus_fabric
// Description : Self-checking bench for data_bus_fabric (3 slaves, TIMEOUT
//               15). A slave model acks after a programmable number of
//               request cycles; expected responses are queued at issue time
//               and compared when core_ready pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_bus_fabric;

    localparam int c_ns      = 3;
    localparam int c_timeout = 15;

    logic             clk;
    logic             reset;
    logic             core_req;
    logic             core_we;
    logic [31:0]      core_addr;
    logic [31:0]      core_wdata;
    logic [3:0]       core_wstrb;
    logic             core_ready;
    logic [31:0]      core_rdata;
    logic             core_err;
    logic [c_ns-1:0]  slv_req;
    logic             slv_we;
    logic [31:0]      slv_addr;
    logic [31:0]      slv_wdata;
    logic [3:0]       slv_wstrb;
    logic [c_ns-1:0]  slv_ack;
    logic [c_ns*32-1:0] slv_rdata;
    logic [15:0]      err_count;

    data_bus_fabric #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .NUM_SLAVES (c_ns),
        .SEL_W      (2),
        .TIMEOUT    (c_timeout),
        .ERR_DATA   (32'hDEAD_BEEF)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_wstrb (core_wstrb),
        .core_ready (core_ready),
        .core_rdata (core_rdata),
        .core_err   (core_err),
        .slv_req    (slv_req),
        .slv_we     (slv_we),
        .slv_addr   (slv_addr),
        .slv_wdata  (slv_wdata),
        .slv_wstrb  (slv_wstrb),
        .slv_ack    (slv_ack),
        .slv_rdata  (slv_rdata),
        .err_count  (err_count)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          t0;   // accept cycle, or -1 when latency is not checked
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cyc          = 0;
    int          sl_lat[c_ns];
    logic [31:0] sl_data[c_ns];
    int          sl_cnt[c_ns];
    logic [c_ns-1:0] stray_ack;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_value(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave model: ack on the (sl_lat+1)-th cycle its request is seen.
    initial begin
        logic [c_ns-1:0] w_ack;
        slv_ack   = '0;
        slv_rdata = '0;
        for (int i = 0; i < c_ns; i++) sl_cnt[i] = 0;
        forever begin
            @(negedge clk);
            w_ack = stray_ack;
            for (int i = 0; i < c_ns; i++) begin
                slv_rdata[i*32 +: 32] = sl_data[i];
                if (slv_req[i]) begin
                    if (sl_cnt[i] == sl_lat[i]) w_ack[i] = 1'b1;
                    sl_cnt[i]++;
                end else begin
                    sl_cnt[i] = 0;
                end
            end
            slv_ack = w_ack;
        end
    end

    // Response monitor / scoreboard.
    initial begin
        exp_t e;
        logic prev_ready;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if ($countones(slv_req) > 1) check_value("slv_req_onehot", 64'(slv_req), 64'd0);
            if (core_ready && prev_ready) check_value("ready_single_cycle", 64'd1, 64'd0);
            if (core_ready) begin
                if (sb.size() == 0) begin
                    check_value("unexpected_ready", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_value("rdata", 64'(core_rdata), 64'(e.rdata));
                    check_value("err", 64'(core_err), 64'(e.err));
                    if (e.t0 >= 0) check_value("latency", 64'(cyc - e.t0), 64'(e.lat));
                end
            end
            prev_ready = core_ready;
        end
    end

    task automatic do_access(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb,
                             input logic [31:0] exp_rdata, input logic exp_err,
                             input int exp_lat);
        exp_t e;
        @(negedge clk);
        core_req   = 1'b1;
        core_we    = we;
        core_addr  = addr;
        core_wdata = wdata;
        core_wstrb = wstrb;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.t0    = cyc;
        e.lat   = exp_lat;
        sb.push_back(e);
        @(negedge clk);
        core_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) return;
        end
        check_value("response_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        exp_t e;
        reset      = 1'b1;
        core_req   = 1'b0;
        core_we    = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
        core_wstrb = '0;
        stray_ack  = '0;
        for (int i = 0; i < c_ns; i++) begin
            sl_lat[i]  = -1;
            sl_data[i] = 32'h0BAD_0000 + 32'(i);
        end

        // Reset state
        repeat (3) @(negedge clk);
        check_value("rst_core_ready", 64'(core_ready), 64'd0);
        check_value("rst_core_err", 64'(core_err), 64'd0);
        check_value("rst_core_rdata", 64'(core_rdata), 64'd0);
        check_value("rst_slv_req", 64'(slv_req), 64'd0);
        check_value("rst_slv_addr", 64'(slv_addr), 64'd0);
        check_value("rst_slv_wdata", 64'(slv_wdata), 64'd0);
        check_value("rst_err_count", 64'(err_count), 64'd0);
        reset = 1'b0;

        // 1: read, slave 1 acks in its first request cycle
        sl_lat[1]  = 0;
        sl_data[1] = 32'h1234_5678;
        do_access(1'b0, 32'h4000_0010, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 2);
        check_value("t1_slv_req", 64'(slv_req), 64'b010);
        check_value("t1_slv_addr", 64'(slv_addr), 64'h4000_0010);
        @(negedge clk);
        check_value("t1_slv_req_drop", 64'(slv_req), 64'd0);
        wait_idle(40);

        // 2: write, slave 0 acks on its third request cycle
        sl_lat[0] = 2;
        do_access(1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 4'b0011, 32'h0, 1'b0, 4);
        for (int k = 0; k < 3; k++) begin
            check_value("t2_slv_req", 64'(slv_req), 64'b001);
            check_value("t2_slv_wdata", 64'(slv_wdata), 64'hA5A5_A5A5);
            check_value("t2_slv_wstrb", 64'(slv_wstrb), 64'b0011);
            check_value("t2_slv_we", 64'(slv_we), 64'd1);
            @(negedge clk);
        end
        wait_idle(40);

        // 3: slave 2 silent -> timeout
        sl_lat[2] = -1;
        do_access(1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, c_timeout + 1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (slv_req == '0) break;
            n++;
            @(negedge clk);
        end
        check_value("t3_req_cycles", 64'(n), 64'(c_timeout));
        wait_idle(40);
        check_value("t3_err_count", 64'(err_count), 64'd1);

        // 4: ack on the final wait cycle wins over the timeout
        sl_lat[2]  = c_timeout - 1;
        sl_data[2] = 32'hCAFE_F00D;
        do_access(1'b0, 32'h8000_0004, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, c_timeout + 1);
        wait_idle(40);
        check_value("t4_err_count", 64'(err_count), 64'd1);

        // 5: unmapped address, then stray ack while idle
        do_access(1'b0, 32'hC000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, 1);
        check_value("t5_no_slv_req", 64'(slv_req), 64'd0);
        wait_idle(40);
        check_value("t5_err_count", 64'(err_count), 64'd2);
        stray_ack = 3'b001;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (core_ready || (slv_req != '0)) n++;
        end
        stray_ack = '0;
        check_value("t5_stray_ack", 64'(n), 64'd0);

        // 6: reset in WAIT aborts the access
        sl_lat[2] = -1;
        @(negedge clk);
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 32'h8000_0000;
        @(negedge clk);
        core_req = 1'b0;
        repeat (2) @(negedge clk);
        check_value("t6_in_wait", 64'(slv_req), 64'b100);
        reset = 1'b1;
        #1;
        check_value("t6_rst_slv_req", 64'(slv_req), 64'd0);
        check_value("t6_rst_ready", 64'(core_ready), 64'd0);
        check_value("t6_rst_err_count", 64'(err_count), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 6b: core_req held high yields two separate responses
        sl_lat[0]  = 0;
        sl_data[0] = 32'h1111_1111;
        sl_lat[1]  = 1;
        sl_data[1] = 32'h2222_2222;
        @(negedge clk);
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 32'h0000_0000;
        e.rdata = 32'h1111_1111; e.err = 1'b0; e.t0 = -1; e.lat = 0;
        sb.push_back(e);
        e.rdata = 32'h2222_2222;
        sb.push_back(e);
        @(negedge clk);
        core_addr = 32'h4000_0000;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() <= 1) break;
            n++;
            @(negedge clk);
            #1;
        end
        if (n == 20) check_value("t6_first_resp_timeout", 64'(sb.size()), 64'd1);
        @(negedge clk);
        @(negedge clk);
        core_req = 1'b0;
        wait_idle(40);
        repeat (3) @(negedge clk);
        check_value("t6_queue_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
